// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator front end and token decoder.
package calc_pkg;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} kp_state_t;

    typedef logic [4:0] token_t;

    localparam token_t TOK_LPAREN = 5'd16;
    localparam token_t TOK_RPAREN = 5'd17;

    // Active-low one-hot column drive: column 0 drives bit 3.
    function automatic logic [3:0] col_drive(input logic [1:0] c);
        col_drive = ~(4'b1000 >> c);
    endfunction

    // Lowest-numbered low row wins; row 0 is bit 3 of the pattern.
    function automatic logic [1:0] first_low_row(input logic [3:0] rows_n);
        casez (rows_n)
            4'b0???: first_low_row = 2'd0;
            4'b10??: first_low_row = 2'd1;
            4'b110?: first_low_row = 2'd2;
            default: first_low_row = 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
module sync_2ff #(
    parameter int unsigned          WIDTH     = 1,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with press/release debounce and merged parenthesis
// buttons; emits one registered token strobe per accepted key.
module keypad_scanner
    import calc_pkg::*;
#(
    parameter int unsigned SCAN_CYCLES     = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    input  logic       paren_left,
    input  logic       paren_right,
    output logic [3:0] col_n,
    output logic [4:0] token,
    output logic       token_valid,
    output logic       busy
);

    localparam int unsigned DW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [3:0] rows_s;
    logic [1:0] parens_s;
    logic [1:0] paren_rise;

    kp_state_t   state_q, state_d;
    logic [1:0]  col_q, col_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]  pat_q, pat_d;
    logic [1:0]  pend_q, pend_d;
    logic [1:0]  paren_prev_q, paren_prev_d;
    logic [3:0]  col_n_q, col_n_d;
    token_t      token_q, token_d;
    logic        token_valid_q, token_valid_d;
    logic        busy_q, busy_d;

    sync_2ff #(.WIDTH(4), .RESET_VAL(4'hF)) u_row_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (row_n),
        .q     (rows_s)
    );

    // Bit 0 is the left button, bit 1 the right button.
    sync_2ff #(.WIDTH(2), .RESET_VAL(2'b00)) u_paren_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({paren_right, paren_left}),
        .q     (parens_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= SCAN;
            col_q         <= 2'd0;
            dwell_q       <= '0;
            cnt_q         <= '0;
            pat_q         <= 4'hF;
            pend_q        <= 2'b00;
            paren_prev_q  <= 2'b00;
            col_n_q       <= 4'b0111;
            token_q       <= '0;
            token_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            dwell_q       <= dwell_d;
            cnt_q         <= cnt_d;
            pat_q         <= pat_d;
            pend_q        <= pend_d;
            paren_prev_q  <= paren_prev_d;
            col_n_q       <= col_n_d;
            token_q       <= token_d;
            token_valid_q <= token_valid_d;
            busy_q        <= busy_d;
        end
    end

    // Scan / debounce / release sequencing; the column is held outside SCAN.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        unique case (state_q)
            SCAN: begin
                if (dwell_q == DW'(SCAN_CYCLES - 1)) begin
                    dwell_d = '0;
                    if (rows_s != 4'hF) begin
                        pat_d   = rows_s;
                        cnt_d   = '0;
                        state_d = DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            DEBOUNCE: begin
                if (rows_s == pat_q) begin
                    if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                        cnt_d   = '0;
                        state_d = PRESSED;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    cnt_d   = '0;
                    col_d   = col_q + 2'd1;
                    state_d = SCAN;
                end
            end
            PRESSED: begin
                cnt_d   = '0;
                state_d = RELEASE;
            end
            RELEASE: begin
                if (rows_s == 4'hF) begin
                    if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                        cnt_d   = '0;
                        col_d   = col_q + 2'd1;
                        state_d = SCAN;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end
        endcase
    end

    // Keypad strobe owns the PRESSED cycle; pending parens go out afterwards, left first.
    always_comb begin
        col_n_d       = col_drive(col_d);
        busy_d        = (state_d != SCAN);
        paren_rise    = parens_s & ~paren_prev_q;
        paren_prev_d  = parens_s;
        token_valid_d = 1'b0;
        token_d       = '0;
        pend_d        = pend_q;
        if (state_q == PRESSED) begin
            token_valid_d = 1'b1;
            token_d       = 5'({first_low_row(pat_q), col_q});
        end else if (pend_q[0]) begin
            token_valid_d = 1'b1;
            token_d       = TOK_LPAREN;
            pend_d[0]     = 1'b0;
        end else if (pend_q[1]) begin
            token_valid_d = 1'b1;
            token_d       = TOK_RPAREN;
            pend_d[1]     = 1'b0;
        end
        pend_d = pend_d | paren_rise;
    end

    assign col_n       = col_n_q;
    assign token       = token_q;
    assign token_valid = token_valid_q;
    assign busy        = busy_q;

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Front-end stage of the musical calculator. It drives the 4x4 keypad columns one at a time (active-low) and reads the active-low rows. It debounces presses and merges the two parenthesis buttons into a single stream. Each accepted key produces exactly one 5-bit token pulse, which goes to the expression/token stage of `top`.

## Interface
- `SCAN_CYCLES`, default 4: clock cycles each column is driven while scanning; must be ≥ 3.
- `DEBOUNCE_CYCLES`, default 8: consecutive stable cycles needed to accept a press or a release.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `row_n`  in  4  keypad rows, active-low, asynchronous to `clk`.
- `paren_left`  in  1  left-parenthesis button, active-high, asynchronous.
- `paren_right`  in  1  right-parenthesis button, active-high, asynchronous.
- `col_n`  out  4  column drive; exactly one bit low at all times.
- `token`  out  5  key code; valid only while `token_valid` is high.
- `token_valid`  out  1  single-cycle strobe, one per accepted key.
- `busy`  out  1  high in DEBOUNCE, PRESSED and RELEASE.

## Operation
- Column index c runs 0..3 and drives `col_n` 0111, 1011, 1101, 1110 respectively.
- Row index r runs 0..3; bit 3 of `row_n` is r=0 and bit 0 is r=3.
- Keypad token = 4·r + c, giving 0..15. TOK_LPAREN = 16, TOK_RPAREN = 17.
- `row_n`, `paren_left` and `paren_right` each pass through a 2-flop synchronizer before any use.
- State machine, with transitions:
  - **SCAN:** on the last cycle of each column dwell, sample synced rows. If any row is low, latch c and the row pattern, then go to DEBOUNCE with the column held. Otherwise advance c (3 wraps to 0).
  - **DEBOUNCE:** each cycle, if the synced pattern equals the latched pattern, increment the counter; otherwise return to SCAN and advance c. When the counter reaches DEBOUNCE_CYCLES, go to PRESSED.
  - **PRESSED:** for one cycle, emit `token` with `token_valid`=1. If several rows are low, the lowest r wins. Then go to RELEASE.
  - **RELEASE:** column stays held. Count consecutive cycles with all synced rows high; any low row resets the count. At DEBOUNCE_CYCLES, go to SCAN and advance c.
- Auto-repeat is not supported: a held key yields exactly one token.
- Parentheses:
  - A rising edge of the synced signal sets that button's pending flag.
  - A pending flag is emitted on the next cycle where the FSM is not in PRESSED, then cleared.
  - Left has priority over right; the right flag stays pending one more cycle.
  - The parenthesis path does not alter the FSM state.

## Timing
- Reset values:
  - `col_n`=0111, `token`=0, `token_valid`=0, `busy`=0.
  - State SCAN, c=0, all counters and pending flags clear.
- Asserting `rst_n` mid-press aborts immediately, with no token.
- Dwell: in SCAN, `col_n` changes exactly every SCAN_CYCLES cycles.
- Press latency:
  - `token_valid` rises exactly DEBOUNCE_CYCLES+1 cycles after entry to DEBOUNCE.
  - From a row going low while its column is driven, latency is ≤ 4·SCAN_CYCLES + DEBOUNCE_CYCLES + 3 cycles.
- Parenthesis latency: the strobe occurs 3 cycles after the raw rising edge, or 4 if blocked by PRESSED.
- `token_valid` is never high two consecutive cycles for the same source.
- Glitch shorter than DEBOUNCE_CYCLES: no token, and scanning resumes at the next column.
- Release bounce: any low row during RELEASE restarts the release count, and no second token is emitted.

## Structure
- Package `calc_pkg` holds:
  - `typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} kp_state_t`;
  - `typedef logic [4:0] token_t`;
  - localparams TOK_LPAREN=16 and TOK_RPAREN=17.
- The downstream token decoder shares `calc_pkg`.
- One sub-module `sync_2ff`, parameterized by width, instantiated for rows (width 4) and parens (width 2).

## Test plan
(SCAN_CYCLES=4 and DEBOUNCE_CYCLES=8 unless stated.)
1. Reset, no keys pressed → `col_n` sequence 0111, 1011, 1101, 1110, 0111, changing every 4 cycles; `token_valid` stays 0.
2. Hold `row_n`=0111 whenever `col_n`=0111, for 60 cycles → exactly one strobe with `token`=0; `busy` high until 8 cycles after release.
3. Drive `row_n`=1101 only while `col_n`=1110, with a 2-cycle bounce at the start and 3 bounces at release → single `token`=11.
4. 5-cycle pulse of `row_n`=1110 on column 1 → no strobe; scanning continues at column 2.
5. `paren_left` rises during PRESSED of key 5; `paren_right` rises the same cycle → token order 5, 16, 17, each a 1-cycle strobe.
6. Assert `rst_n` low during DEBOUNCE → `col_n`=0111, no token; after release a fresh press of key 0 yields `token`=0.
